alu_mul_seq: RTL and testbench

// - Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) in the execute stage; owns no adder.
// - Borrows the shared ALU: drives alu_opcode/src1/src2 each busy cycle, consumes alu_adder_result/alu_result.
// - alu_busy tells the execute stage to stall and yield the ALU.
// - Valid/ready request and response handshakes; 1 op in flight.

---
 rtl/alu_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) that borrows the shared execute-stage ALU for every add/sub.
// Optional macro MUL_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        kill,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        alu_busy,
  output logic [7:0]  alu_opcode,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_adder_result,
  input  logic [31:0] alu_result
);

  localparam int XLEN         = 32;
  localparam int ALU_OP_WIDTH = 8;
  localparam int ALU_OP_ADD   = 0;
  localparam int ALU_OP_SUB   = 1;
  localparam int ALU_OP_XOR   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEG_A  = 3'd1;
  localparam logic [2:0] S_NEG_B  = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_FIX_LO = 3'd4;
  localparam logic [2:0] S_FIX_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]      r_state;
  logic [4:0]      r_cnt;
  logic [1:0]      r_op;
  logic            r_neg_b;
  logic            r_neg_res;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_carry;
  logic            w_early;
  logic [2:0]      w_post_mul;

  assign w_a_sgn    = (req_op == 2'b01) || (req_op == 2'b10);
  assign w_b_sgn    = (req_op == 2'b01);
  assign w_a_neg    = w_a_sgn & req_src1[XLEN-1];
  assign w_b_neg    = w_b_sgn & req_src2[XLEN-1];
  assign w_post_mul = r_neg_res ? S_FIX_LO : S_DONE;

`ifdef MUL_EARLY_TERM_EN
  logic [5:0]        w_shamt;
  logic [2*XLEN-1:0] w_shifted;

  // Bits lo[31-cnt:0] are the multiplier bits not yet consumed.
  assign w_early   = (r_state == S_MUL) && ((r_lo & (32'hFFFF_FFFF >> r_cnt)) == '0);
  assign w_shamt   = 6'd32 - {1'b0, r_cnt};
  assign w_shifted = {r_hi, r_lo} >> w_shamt;
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    alu_opcode = '0;
    alu_src1   = '0;
    alu_src2   = '0;
    case (r_state)
      S_NEG_A: begin
        alu_opcode[ALU_OP_SUB] = 1'b1;
        alu_src2               = r_mcand;
      end
      S_NEG_B: begin
        alu_opcode[ALU_OP_SUB] = 1'b1;
        alu_src2               = r_lo;
      end
      S_MUL: begin
        if (!w_early) begin
          alu_opcode[ALU_OP_ADD] = 1'b1;
          alu_src1               = r_hi;
          alu_src2               = r_lo[0] ? r_mcand : '0;
        end
      end
      S_FIX_LO: begin
        alu_opcode[ALU_OP_SUB] = 1'b1;
        alu_src2               = r_lo;
      end
      S_FIX_HI: begin
        // lo is already negated; -x==0 exactly when x==0, so it still tells us whether a borrow reaches hi.
        if (r_lo == '0) begin
          alu_opcode[ALU_OP_SUB] = 1'b1;
          alu_src2               = r_hi;
        end else begin
          alu_opcode[ALU_OP_XOR] = 1'b1;
          alu_src1               = r_hi;
          alu_src2               = 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

  // The ALU returns only a 32-bit sum, so the carry out is rebuilt from the operand and sum MSBs.
  assign w_carry = (r_hi[XLEN-1] & alu_src2[XLEN-1]) |
                   ((r_hi[XLEN-1] | alu_src2[XLEN-1]) & ~alu_adder_result[XLEN-1]);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_b   <= 1'b0;
      r_neg_res <= 1'b0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (kill && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && !kill) begin
            r_op      <= req_op;
            r_mcand   <= req_src1;
            r_lo      <= req_src2;
            r_hi      <= '0;
            r_cnt     <= '0;
            r_neg_b   <= w_b_neg;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_state   <= w_a_neg ? S_NEG_A : (w_b_neg ? S_NEG_B : S_MUL);
          end
        end
        S_NEG_A: begin
          r_mcand <= alu_adder_result;
          r_state <= r_neg_b ? S_NEG_B : S_MUL;
        end
        S_NEG_B: begin
          r_lo    <= alu_adder_result;
          r_state <= S_MUL;
        end
        S_MUL: begin
          if (w_early) begin
`ifdef MUL_EARLY_TERM_EN
            {r_hi, r_lo} <= w_shifted;
`endif
            r_state <= w_post_mul;
          end else begin
            r_hi  <= {w_carry, alu_adder_result[XLEN-1:1]};
            r_lo  <= {alu_adder_result[0], r_lo[XLEN-1:1]};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= w_post_mul;
          end
        end
        S_FIX_LO: begin
          r_lo    <= alu_adder_result;
          r_state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          r_hi    <= (r_lo == '0) ? alu_adder_result : alu_result;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_DONE);
  assign alu_busy   = (r_state != S_IDLE);
  assign rsp_result = (r_state != S_DONE) ? '0 : ((r_op == 2'b00) ? r_lo : r_hi);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: models the shared ALU, runs directed vectors,
// random operations against a 64-bit arithmetic reference, and kill/reset/stall sequences.
module tb_alu_mul_seq;

  localparam int ALU_OP_ADD = 0;
  localparam int ALU_OP_SUB = 1;
  localparam int ALU_OP_XOR = 4;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        kill;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        alu_busy;
  logic [7:0]  alu_opcode;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_adder_result;
  logic [31:0] alu_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_src1         (req_src1),
    .req_src2         (req_src2),
    .kill             (kill),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .alu_busy         (alu_busy),
    .alu_opcode       (alu_opcode),
    .alu_src1         (alu_src1),
    .alu_src2         (alu_src2),
    .alu_adder_result (alu_adder_result),
    .alu_result       (alu_result)
  );

  // Shared ALU stand-in
  always_comb begin
    alu_adder_result = alu_opcode[ALU_OP_SUB] ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);
    alu_result       = alu_opcode[ALU_OP_XOR] ? (alu_src1 ^ alu_src2) : alu_adder_result;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat_full;
    int          lat_et;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit          na;
    bit          nb;
    logic [31:0] mb;
    int          mc;
    na = (op == 2'b01 || op == 2'b10) && a[31];
    nb = (op == 2'b01) && b[31];
    mb = nb ? (32'h0 - b) : b;
    mc = 32;
    if (EARLY_TERM) begin
      mc = 1;
      for (int k = 0; k < 32; k++) if ((mb >> k) != 0) mc = k + 2;
      if (mc > 32) mc = 32;
    end
    return 1 + int'(na) + int'(nb) + mc + ((na ^ nb) ? 2 : 0);
  endfunction

  // Called on a falling edge with the DUT idle; returns on a falling edge after the response handshake.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = rsp_result;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu_busy"}, 32'(alu_busy), 32'd0);
    check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_alu_src1"}, alu_src1, 32'd0);
    check({tag, "_alu_src2"}, alu_src2, 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
  endtask

  vec_t        vecs[9];
  logic [31:0] specials[5];
  logic [31:0] res;
  int          lat;
  int          seen;
  int          w;

  initial begin
    rst_b     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = '0;
    req_src2  = '0;
    kill      = 1'b0;
    rsp_ready = 1'b0;

    vecs[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33};
    vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 33};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 36, 7};
    vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 33, 4};
    vecs[4] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 35};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 36, 36};
    vecs[6] = '{2'b11, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 33, 4};
    vecs[7] = '{2'b00, 32'h1234_5678, 32'h0000_0003, 32'h369D_0368, 33, 4};
    vecs[8] = '{2'b00, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 33, 2};
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(EARLY_TERM ? vecs[i].lat_et : vecs[i].lat_full));
      check($sformatf("vec%0d_idle_after", i), 32'(req_ready), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(20, 31);
      run_op(op, a, b, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h_result", i, op, a, b), res, ref_result(op, a, b));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
    end

    // Response stall with a competing request
    start_op(2'b00, 32'h0000_0007, 32'h0000_0006);
    w = 1;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("stall_reach_done", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_src1  = 32'hDEAD_BEEF;
    req_src2  = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_rsp_result", i), rsp_result, 32'd42);
      check($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check("handshake_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_handshake_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_handshake_alu_busy", 32'(alu_busy), 32'd0);
    @(negedge clk);
    check("no_late_accept", 32'(alu_busy), 32'd0);

    // Kill during MUL iteration 10
    start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    check("kill_mid_mul_opcode", 32'(alu_opcode), 32'(1 << ALU_OP_ADD));
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_alu_busy", 32'(alu_busy), 32'd0);
    check("kill_req_ready", 32'(req_ready), 32'd1);
    check("kill_alu_opcode", 32'(alu_opcode), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("kill_no_response", 32'(seen), 32'd0);

    // Kill in idle blocks the request
    req_valid = 1'b1;
    kill      = 1'b1;
    req_op    = 2'b00;
    req_src1  = 32'h3;
    req_src2  = 32'h5;
    @(negedge clk);
    req_valid = 1'b0;
    kill      = 1'b0;
    check("idle_kill_not_accepted", 32'(alu_busy), 32'd0);

    // Kill in DONE beats rsp_ready
    start_op(2'b00, 32'h0000_0007, 32'h0000_0009);
    w = 1;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("done_kill_reach_done", 32'(rsp_valid), 32'd1);
    kill      = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    kill      = 1'b0;
    rsp_ready = 1'b0;
    check("done_kill_rsp_valid", 32'(rsp_valid), 32'd0);
    check("done_kill_alu_busy", 32'(alu_busy), 32'd0);

    // Asynchronous reset at MUL iteration 20
    start_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(alu_busy), 32'd1);
    #2 rst_b = 1'b0;
    #1 check_idle_outputs("midop_reset");
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, res, lat);
    check("after_reset_result", res, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
